// File: rtl/delay_sched.sv
// Round-robin arbiter sharing one programmable delay counter among NREQ requesters.
// The winner holds gnt for LOAD + tgt RUN cycles + DONE, with a done pulse in DONE.
module delay_sched #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned CBITS = 14,
   parameter int unsigned N     = 10000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CBITS-1:0]   dly,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic                    busy,
   output logic                    err
);

   localparam int unsigned PBITS = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("delay_sched: NREQ must be in 2..8");
   end
   if (N == 0 || 64'(N) >= (64'd1 << CBITS)) begin : g_bad_n
      $error("delay_sched: N must be nonzero and fit in CBITS");
   end

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [CBITS-1:0]   cnt, tgt, winner_dly;
   logic [PBITS-1:0]   owner, rr_ptr, winner, cand;
   logic               found;
   int unsigned        idx;

   // Search upward from the slot after the last winner, wrapping modulo NREQ.
   always_comb begin
      winner     = '0;
      winner_dly = '0;
      found      = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx  = (32'(rr_ptr) + k) % NREQ;
         cand = PBITS'(idx);
         if (!found && req[cand]) begin
            found      = 1'b1;
            winner     = cand;
            winner_dly = dly[idx*CBITS +: CBITS];
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (found) state_nx = LOAD;
         LOAD: state_nx = req[owner] ? RUN : IDLE;
         RUN: begin
            if (!req[owner])
               state_nx = IDLE;
            else if (cnt == tgt - CBITS'(1))
               state_nx = DONE;
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gnt  = '0;
      done = '0;
      busy = (state != IDLE);
      err  = (state == RUN) && (cnt > tgt);
      if (state != IDLE)
         gnt[owner] = 1'b1;
      if (state == DONE)
         done[owner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         tgt    <= '0;
         owner  <= '0;
         rr_ptr <= PBITS'(NREQ - 1);
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (found) begin
                  owner  <= winner;
                  rr_ptr <= winner;
                  tgt    <= (winner_dly == '0) ? CBITS'(N) : winner_dly;
               end
            end
            LOAD: cnt <= '0;
            RUN:  cnt <= req[owner] ? cnt + CBITS'(1) : '0;
            // cnt reaches tgt on entry to DONE; clear it so the next tgt load keeps cnt <= tgt
            DONE: cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_done_owner:  assert property (@(posedge clk) disable iff (rst) (done != '0) |-> (done == gnt));
   a_done_pulse:  assert property (@(posedge clk) disable iff (rst) (done != '0) |=> (done == '0));
   a_no_err:      assert property (@(posedge clk) disable iff (rst) !err);
   a_busy_gnt:    assert property (@(posedge clk) disable iff (rst) busy == (gnt != '0));
   a_cnt_le_tgt:  assert property (@(posedge clk) disable iff (rst) cnt <= tgt);

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: table of single-request vectors plus hand-built sequences,
// with done pulses checked against a queue of expected {owner, cycle} entries.
module tb_delay_sched;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned CBITS = 14;
   localparam int unsigned N     = 10000;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ*CBITS-1:0]  dly;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        done;
   logic                   busy;
   logic                   err;

   delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .dly  (dly),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .err  (err)
   );

   typedef struct {
      logic [NREQ-1:0] vec;
      int              cyc;
   } exp_t;

   typedef struct {
      logic [NREQ-1:0] req_v;
      int              idx;
      int              d;
      int              len;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   errs  = 0;
   int   cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done !== '0) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got %0h expected none (cycle %0d)", done, cyc);
         end else begin
            e = sb.pop_front();
            check("done_vec", 32'(done), 32'(e.vec));
            check("done_cyc", cyc, e.cyc);
         end
      end
      if (!rst && err !== 1'b0) errs++;
   end

   task automatic wait_done(input int lim);
      int i = 0;
      while (done === '0 && i < lim) begin
         @(negedge clk);
         i++;
      end
      check("done_seen", 32'(done != '0), 1);
   endtask

   task automatic push_exp(input logic [NREQ-1:0] v, input int c);
      exp_t e;
      e.vec = v;
      e.cyc = c;
      sb.push_back(e);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t            tbl[5];
      int              t0;
      logic [NREQ-1:0] bits;

      tbl[0] = '{4'b0001, 0, 5, 5};
      tbl[1] = '{4'b0100, 2, 0, 10000};
      tbl[2] = '{4'b0010, 1, 1, 1};
      tbl[3] = '{4'b1000, 3, 16383, 16383};
      tbl[4] = '{4'b0010, 1, 2, 2};

      rst = 1'b1;
      req = '0;
      dly = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt",  32'(gnt),  0);
      check("rst_done", 32'(done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err",  32'(err),  0);
      rst = 1'b0;
      while (cyc < 10) @(negedge clk);

      // Single-request vectors: gnt at t0+1, done at t0+2+len, release one cycle later.
      for (int v = 0; v < 5; v++) begin
         dly = '0;
         dly[tbl[v].idx*CBITS +: CBITS] = CBITS'(tbl[v].d);
         req = tbl[v].req_v;
         t0  = cyc;
         push_exp(tbl[v].req_v, t0 + 2 + tbl[v].len);
         @(negedge clk);
         check("gnt_load",  32'(gnt),  32'(tbl[v].req_v));
         check("busy_load", 32'(busy), 1);
         dly = '1;
         wait_done(tbl[v].len + 8);
         req = '0;
         @(negedge clk);
         check("gnt_release",  32'(gnt),  0);
         check("busy_release", 32'(busy), 0);
         @(negedge clk);
      end

      // Abort: req[1] drops in its 7th RUN cycle; req[3], raised during LOAD, wins next.
      dly = '0;
      dly[1*CBITS +: CBITS] = CBITS'(20);
      dly[3*CBITS +: CBITS] = CBITS'(4);
      req = 4'b0010;
      t0  = cyc;
      @(negedge clk);
      check("abort_gnt1", 32'(gnt), 32'(4'b0010));
      req[3] = 1'b1;
      repeat (7) @(negedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_idle_gnt",  32'(gnt),  0);
      push_exp(4'b1000, t0 + 15);
      @(negedge clk);
      check("abort_gnt3", 32'(gnt), 32'(4'b1000));
      wait_done(12);
      req = '0;
      repeat (2) @(negedge clk);

      // Round robin: all four held at dly=3, each drops req for one cycle after its done.
      dly = '0;
      for (int i = 0; i < NREQ; i++) dly[i*CBITS +: CBITS] = CBITS'(3);
      req = 4'b1111;
      t0  = cyc;
      for (int k = 0; k < 5; k++) push_exp(4'b0001 << (k % 4), t0 + 5 + 6*k);
      for (int k = 0; k < 5; k++) begin
         wait_done(20);
         bits = done;
         if (k == 4) req = '0;
         else        req = req & ~bits;
         @(negedge clk);
         if (k < 4) req = req | bits;
      end
      repeat (2) @(negedge clk);

      // Reset in RUN with cnt=9, tgt=15: no done, outputs clear, pointer back to NREQ-1.
      dly = '0;
      dly[2*CBITS +: CBITS] = CBITS'(15);
      req = 4'b0100;
      t0  = cyc;
      @(negedge clk);
      check("rstmid_gnt", 32'(gnt), 32'(4'b0100));
      repeat (10) @(negedge clk);
      check("rstmid_busy_run", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_gnt0",  32'(gnt),  0);
      check("rstmid_done0", 32'(done), 0);
      check("rstmid_busy0", 32'(busy), 0);
      check("rstmid_err0",  32'(err),  0);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) dly[i*CBITS +: CBITS] = CBITS'(2);
      req = 4'b1111;
      t0  = cyc;
      push_exp(4'b0001, t0 + 4);
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
      wait_done(10);
      req = '0;
      repeat (5) @(negedge clk);

      check("sb_empty",   sb.size(), 0);
      check("err_cycles", errs, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
